// File: rtl/serial_cla_adder.sv
// Wide adder that reuses one 4-bit CLA slice, one nibble per cycle, LSB first.
// Result valid NIB edges after accept; held in DONE until out_ready, no accept while busy.

module ocla (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign Sum  = w_p ^ w_c[3:0];
  assign Cout = w_c[4];
endmodule

module serial_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_vld;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_nib_sum;
  logic             w_nib_cout;
  logic             w_last;

  assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];
  assign w_last  = (r_idx == IW'(NIB - 1));

  ocla u_ocla (
    .A    (w_nib_a),
    .B    (w_nib_b),
    .Cin  (r_carry),
    .Sum  (w_nib_sum),
    .Cout (w_nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_nib_sum;
          r_carry                    <= w_nib_cout;
          if (w_last) begin
            r_cout    <= w_nib_cout;
            // Top nibble's Sum[3] is the result sign bit.
            r_ovf     <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nib_sum[3] != r_a[WIDTH-1]);
            r_out_vld <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: doc/serial_cla_adder.md
Name: serial_cla_adder

Overview:
Multi-cycle wide adder built around one instance of the team's 4-bit carry-lookahead slice, OCLA (ports A, B, Cin, Sum, Cout). It accepts WIDTH-bit operand pairs over a valid/ready handshake. It sums them one nibble per cycle, LSB first, with a registered inter-nibble carry. It presents the result on a held valid/ready output, which lets the datapath add wide words without replicating CLA hardware.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4
NIB, WIDTH/4, derived (localparam): number of nibble slices processed per operation

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair presented
in_ready  out  1  block can accept an operand pair
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in to bit 0
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
sum  out  WIDTH  a + b + cin, low WIDTH bits
cout  out  1  carry out of bit WIDTH-1
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; nibble index=0; carry reg=0; operand regs=0.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE), combinational from state only.
- IDLE: on an edge with in_valid&&in_ready, latch a, b; carry<=cin; idx<=0; go RUN. Otherwise hold.
- RUN: the OCLA slice is fed A=a_reg[4*idx+:4], B=b_reg[4*idx+:4], Cin=carry. Each edge:
  - sum[4*idx+:4] <= Sum; carry <= Cout.
  - If idx==NIB-1: cout<=Cout; ovf<=(a_reg[W-1]==b_reg[W-1]) && (Sum[3]!=a_reg[W-1]); out_valid<=1; go DONE.
  - Else idx<=idx+1.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16; 1 for WIDTH=4).
- DONE: sum/cout/ovf/out_valid held stable while out_ready=0. On an edge with out_ready=1: out_valid<=0, go IDLE. No new accept occurs on that same edge.
- Throughput: one operation per NIB+2 cycles minimum.
- in_valid while not in IDLE: ignored. Operands are not sampled and nothing is queued.
- Result width: the sum wraps modulo 2^WIDTH; the carry is reported only on cout.
- sum bits not yet written in RUN keep their previous value. Only sum in DONE is meaningful.
- out_ready asserted outside DONE has no effect.
- rst_n asserted in RUN or DONE aborts the operation immediately. All outputs return to reset values and the pending result is lost.
- idx counter width is clog2(NIB), minimum 1 bit.

Test Plan:
- WIDTH=16, a=0x0001, b=0x0001, cin=0, out_ready=1 -> out_valid 4 cycles after accept; sum=0x0002, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles). a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout, ovf unchanged and in_ready=0 throughout. A new in_valid with a=0x1234 is ignored. Raising out_ready -> IDLE next edge, in_ready=1.
- Drop rst_n to 0 mid-RUN (after 2 nibbles) -> outputs immediately return to reset values. After release, the next op a=0x00F0, b=0x0010 -> sum=0x0100.
- WIDTH=4 instance: a=0xF, b=0x1, cin=1 -> out_valid 1 cycle after accept; sum=0x1, cout=1, ovf=0.
